// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests into the stall vector, turns
// mem-stage exceptions into a one-cycle flush with redirect, and tracks stall stats.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
   parameter logic [15:0] STALL_TIMEOUT = 16'd1024,
   parameter int          CNT_W         = 32
) (
   input  logic             clk,
   input  logic             Rst_n,
   input  logic             stallreq_id_i,
   input  logic             stallreq_ex_i,
   input  logic             stallreq_mem_i,
   input  logic [31:0]      excepttype_i,
   input  logic [31:0]      cp0_epc_i,
   input  logic             perf_clr_i,
   output logic [5:0]       stall_o,
   output logic             flush_o,
   output logic [31:0]      new_pc_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             stall_timeout_o
);

   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t      state, state_nxt;
   logic [5:0]  stall_req;
   logic [15:0] wd_cnt;
   logic        exc_take;

   // Holding stage N while N+1 runs makes N+1's register insert a bubble.
   always_comb begin
      stall_req = 6'b000000;
      if (stallreq_mem_i)     stall_req = 6'b011111;
      else if (stallreq_ex_i) stall_req = 6'b001111;
      else if (stallreq_id_i) stall_req = 6'b000111;
   end

   assign exc_take = (state == RUN) && (excepttype_i != 32'd0);

   always_ff @(posedge clk or posedge Rst_n) begin
      if (Rst_n) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_o   = 6'b000000;
      flush_o   = 1'b0;
      case (state)
         RUN: begin
            if (!Rst_n) stall_o = stall_req;
            if (exc_take) state_nxt = FLUSH;
         end
         FLUSH: begin
            flush_o   = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge Rst_n) begin
      if (Rst_n)         new_pc_o <= 32'd0;
      else if (exc_take) new_pc_o <= (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
   end

   always_ff @(posedge clk or posedge Rst_n) begin
      if (Rst_n)                                  stall_cnt_o <= '0;
      else if (perf_clr_i)                        stall_cnt_o <= '0;
      else if (stall_o != 6'd0 && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
   end

   // Watchdog count parks at STALL_TIMEOUT so the sticky flag trips only once per run.
   always_ff @(posedge clk or posedge Rst_n) begin
      if (Rst_n)                                  wd_cnt <= 16'd0;
      else if (state == FLUSH || !stallreq_mem_i) wd_cnt <= 16'd0;
      else if (wd_cnt != STALL_TIMEOUT)           wd_cnt <= wd_cnt + 16'd1;
   end

   always_ff @(posedge clk or posedge Rst_n) begin
      if (Rst_n)           stall_timeout_o <= 1'b0;
      else if (perf_clr_i) stall_timeout_o <= 1'b0;
      else if (state == RUN && stallreq_mem_i && wd_cnt == STALL_TIMEOUT - 16'd1)
         stall_timeout_o <= 1'b1;
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle model pushes expected outputs as
// stimulus is driven; a monitor pops and compares them each cycle.
module tb_pipe_ctrl;
   localparam int          CNT_W = 4;
   localparam logic [15:0] TO    = 16'd4;
   localparam logic [31:0] VEC   = 32'h0000_0020;

   logic             clk = 1'b0;
   logic             Rst_n;
   logic             id, ex, mem, clr;
   logic [31:0]      exc, epc;
   logic [5:0]       stall_o;
   logic             flush_o, stall_timeout_o;
   logic [31:0]      new_pc_o;
   logic [CNT_W-1:0] stall_cnt_o;

   int errs   = 0;
   int checks = 0;

   pipe_ctrl #(.EXC_VECTOR(VEC), .STALL_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
      .clk(clk), .Rst_n(Rst_n),
      .stallreq_id_i(id), .stallreq_ex_i(ex), .stallreq_mem_i(mem),
      .excepttype_i(exc), .cp0_epc_i(epc), .perf_clr_i(clr),
      .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
      .stall_cnt_o(stall_cnt_o), .stall_timeout_o(stall_timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [5:0]       stall;
      logic             flush;
      logic [31:0]      pc;
      logic [CNT_W-1:0] cnt;
      logic             to;
   } exp_t;

   exp_t sb[$];

   logic             m_fl, m_to;
   logic [31:0]      m_pc;
   logic [CNT_W-1:0] m_cnt;
   logic [15:0]      m_wd;

   task automatic model_reset();
      m_fl = 1'b0; m_to = 1'b0; m_pc = 32'd0; m_cnt = '0; m_wd = 16'd0;
   endtask

   // One cycle: drive at negedge, push expected pre-edge outputs, advance model.
   task automatic cyc(input logic i_id, i_ex, i_mem, input logic [31:0] i_exc, i_epc,
                      input logic i_clr);
      exp_t e;
      @(negedge clk);
      id = i_id; ex = i_ex; mem = i_mem; exc = i_exc; epc = i_epc; clr = i_clr;
      e.stall = m_fl   ? 6'b000000 :
                i_mem  ? 6'b011111 :
                i_ex   ? 6'b001111 :
                i_id   ? 6'b000111 : 6'b000000;
      e.flush = m_fl;  e.pc = m_pc;  e.cnt = m_cnt;  e.to = m_to;
      sb.push_back(e);
      if (i_clr) m_to = 1'b0;
      else if (!m_fl && i_mem && m_wd == TO - 16'd1) m_to = 1'b1;
      if (m_fl || !i_mem) m_wd = 16'd0;
      else if (m_wd != TO) m_wd = m_wd + 16'd1;
      if (i_clr) m_cnt = '0;
      else if (e.stall != 6'd0 && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (!m_fl && i_exc != 32'd0) begin
         m_fl = 1'b1;
         m_pc = (i_exc == 32'h0000_000e) ? i_epc : VEC;
      end else m_fl = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 32'd0, 0);
   endtask

   task automatic release_rst();
      @(negedge clk);
      id = 0; ex = 0; mem = 0; exc = 32'd0; epc = 32'd0; clr = 0;
      Rst_n = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("stall_o", {26'd0, stall_o}, {26'd0, e.stall});
         chk("flush_o", {31'd0, flush_o}, {31'd0, e.flush});
         chk("new_pc_o", new_pc_o, e.pc);
         chk("stall_cnt_o", {28'd0, stall_cnt_o}, {28'd0, e.cnt});
         chk("stall_timeout_o", {31'd0, stall_timeout_o}, {31'd0, e.to});
      end
   end

   initial begin
      Rst_n = 1'b1; id = 0; ex = 0; mem = 0; exc = 32'd0; epc = 32'd0; clr = 0;
      model_reset();
      #12;
      chk("rst_stall", {26'd0, stall_o}, 32'd0);
      chk("rst_cnt", {28'd0, stall_cnt_o}, 32'd0);
      release_rst();

      // priority mem > ex > id, counter tracks stalled cycles
      cyc(0, 0, 0, 32'd0, 32'd0, 1);
      cyc(1, 0, 0, 32'd0, 32'd0, 0);
      cyc(1, 1, 0, 32'd0, 32'd0, 0);
      cyc(1, 1, 1, 32'd0, 32'd0, 0);
      cyc(0, 0, 0, 32'd0, 32'd0, 0);
      #3 chk("t2_cnt", {28'd0, stall_cnt_o}, 32'd3);

      // exception during ex stall, then eret
      cyc(0, 1, 0, 32'h1, 32'd0, 0);
      cyc(0, 1, 0, 32'd0, 32'd0, 0);
      #3 chk("t3_flush", {31'd0, flush_o}, 32'd1);
      chk("t3_pc", new_pc_o, 32'h20);
      cyc(0, 0, 0, 32'd0, 32'd0, 0);
      cyc(0, 0, 0, 32'he, 32'h0000_1234, 0);
      cyc(0, 0, 0, 32'd0, 32'd0, 0);
      #3 chk("t3_eret_pc", new_pc_o, 32'h1234);
      idle(1);

      // back-to-back exceptions: 2 cycles -> one pulse, 3 cycles -> two pulses
      cyc(0, 0, 0, 32'h5, 32'd0, 0);
      cyc(1, 0, 1, 32'h5, 32'd0, 0);
      idle(2);
      cyc(0, 0, 0, 32'h4, 32'd0, 0);
      cyc(0, 0, 0, 32'he, 32'h0000_5678, 0);
      cyc(0, 0, 0, 32'he, 32'h0000_5678, 0);
      idle(2);

      // watchdog
      cyc(0, 0, 0, 32'd0, 32'd0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'd0, 32'd0, 0);
      idle(1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'd0, 32'd0, 0);
      idle(2);
      #3 chk("t5_flag", {31'd0, stall_timeout_o}, 32'd1);
      cyc(0, 0, 0, 32'd0, 32'd0, 1);
      cyc(0, 0, 0, 32'd0, 32'd0, 0);
      #3 chk("t5_clr_flag", {31'd0, stall_timeout_o}, 32'd0);
      chk("t5_clr_cnt", {28'd0, stall_cnt_o}, 32'd0);
      // clear coincident with the trip edge wins
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'd0, 32'd0, 0);
      cyc(0, 0, 1, 32'd0, 32'd0, 1);
      cyc(0, 0, 0, 32'd0, 32'd0, 0);
      #3 chk("t5_clr_wins", {31'd0, stall_timeout_o}, 32'd0);

      // saturation
      cyc(0, 0, 0, 32'd0, 32'd0, 1);
      for (int i = 0; i < 20; i++) cyc(1, 0, 0, 32'd0, 32'd0, 0);
      cyc(0, 0, 0, 32'd0, 32'd0, 0);
      #3 chk("t6_sat", {28'd0, stall_cnt_o}, 32'hF);

      // asynchronous reset mid-cycle with all requests high
      for (int i = 0; i < 2; i++) cyc(1, 1, 1, 32'd0, 32'd0, 0);
      #4 Rst_n = 1'b1;
      #1 chk("arst_stall", {26'd0, stall_o}, 32'd0);
      chk("arst_flush", {31'd0, flush_o}, 32'd0);
      chk("arst_cnt", {28'd0, stall_cnt_o}, 32'd0);
      model_reset();
      release_rst();

      // reset asserted during FLUSH
      cyc(0, 0, 0, 32'h3, 32'd0, 0);
      cyc(1, 1, 1, 32'd0, 32'd0, 0);
      #4 Rst_n = 1'b1;
      #1 chk("fl_rst_flush", {31'd0, flush_o}, 32'd0);
      chk("fl_rst_pc", new_pc_o, 32'd0);
      chk("fl_rst_stall", {26'd0, stall_o}, 32'd0);
      model_reset();
      release_rst();
      idle(2);

      @(negedge clk);
      #5;
      if (sb.size() != 0) chk("sb_drain", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
